// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, fetch FSM states, buffer entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response, decode handshake and redirect.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    input  redirect, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );

  modport slave (
    output redirect, redirect_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr}, head shown combinationally, flush wins.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher feeding a small buffer to decode, with redirect support.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt, inflight_pc;
  logic            discard, discard_nxt;
  logic            push, pop, empty;
  logic [CW-1:0]   count;
  fetch_entry_t    head, push_entry;

  assign pop        = !empty && bus.if_ready && !bus.redirect;
  assign push_entry = '{pc: inflight_pc, instr: bus.imem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      discard     <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      state   <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard <= discard_nxt;
      if (bus.imem_req && bus.imem_gnt) inflight_pc <= fetch_pc;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    discard_nxt  = discard;
    bus.imem_req = 1'b0;
    push         = 1'b0;
    case (state)
      // Nothing is outstanding in IDLE, so buffer occupancy alone gates the next request.
      IDLE: if (bus.redirect || int'(count) < DEPTH) state_nxt = REQ;
      REQ: begin
        bus.imem_req = 1'b1;
        if (bus.imem_gnt) begin
          state_nxt    = WAIT;
          fetch_pc_nxt = fetch_pc + PC_INC;
          discard_nxt  = bus.redirect;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          discard_nxt = 1'b0;
          if (bus.redirect || discard) begin
            state_nxt = REQ;
          end else begin
            push      = 1'b1;
            state_nxt = (int'(count) + 1 - int'(pop) < DEPTH) ? REQ : IDLE;
          end
        end else if (bus.redirect) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Redirect always wins over the sequential increment, including a same-cycle grant.
    if (bus.redirect) fetch_pc_nxt = word_align(bus.redirect_target);
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (push_entry),
    .head  (head),
    .empty (empty),
    .count (count)
  );

  assign bus.imem_addr   = fetch_pc;
  assign bus.if_valid    = !empty;
  assign bus.if_instr    = head.instr;
  assign bus.if_pc       = head.pc;
  assign bus.if_pc_plus4 = head.pc + PC_INC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: queue-based stream model plus directed literal checks.
module tb_instr_fetch_unit;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_unit_if f();
  instr_fetch_unit_if f2();

  instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(f));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .bus(f2));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // stimulus knobs
  int gnt_pct = 100, rdy_pct = 100, stray_pct = 0, redir_pct = 0, max_dly = 0, fixed_dly = 0;
  bit          force_rdr = 0;
  logic [31:0] force_tgt = '0;

  // model: expected buffer contents, expected fetch address, pending memory response
  logic [31:0] q[$];
  logic [31:0] exp_fetch;
  bit          pend, pend_live;
  int          pend_dly;
  logic [31:0] pend_addr;
  int          streak;

  // observation
  int          tick_no, first_valid;
  logic [31:0] popped[$];
  bit          last_hs;
  logic [31:0] last_hs_addr;

  // wrap-around instance captures
  int          n2 = 0;
  logic [31:0] cap_pc[2], cap_p4[2], cap_in[2];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    if (popped.size() > i) return popped[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (q.size() != 0);
    cmp("if_valid", 32'(f.if_valid), 32'(ev));
    if (ev) begin
      cmp("if_pc", f.if_pc, q[0]);
      cmp("if_instr", f.if_instr, memfn(q[0]));
      cmp("if_pc_plus4", f.if_pc_plus4, q[0] + 32'd4);
    end
    if (f.imem_req) cmp("imem_addr", f.imem_addr, exp_fetch);
    cmp("one_outstanding", 32'(f.imem_req && pend), 32'd0);
    cmp("no_req_when_full", 32'(f.imem_req && q.size() == DEPTH), 32'd0);
    if (!f.imem_req && !pend && q.size() < DEPTH) streak++;
    else streak = 0;
    cmp("fetch_stall", 32'(streak > 2), 32'd0);
  endtask

  task automatic tick();
    bit rv, g, rd, rdy, hs, pop, push;
    logic [31:0] tgt;
    @(negedge clk);
    tick_no++;
    check_outputs();
    if (f.if_valid && first_valid == 0) first_valid = tick_no;
    rv = pend && pend_dly == 0;
    if (!pend && int'($urandom_range(99)) < stray_pct) rv = 1'b1;
    g   = int'($urandom_range(99)) < gnt_pct;
    rdy = int'($urandom_range(99)) < rdy_pct;
    rd  = force_rdr || (int'($urandom_range(99)) < redir_pct);
    tgt = force_rdr ? force_tgt : $urandom;
    force_rdr = 1'b0;
    f.imem_gnt        = g;
    f.imem_rvalid     = rv;
    f.imem_rdata      = (pend && rv) ? memfn(pend_addr) : $urandom;
    f.if_ready        = rdy;
    f.redirect        = rd;
    f.redirect_target = tgt;
    // advance the model across the coming rising edge
    hs   = f.imem_req && g;
    pop  = (q.size() != 0) && rdy;
    push = pend && rv && pend_live && !rd;
    if (f.if_valid && rdy && !rd) popped.push_back(f.if_pc);
    if (rd) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(pend_addr);
    end
    if (pend) begin
      if (rv) pend = 1'b0;
      else begin
        pend_dly--;
        if (rd) pend_live = 1'b0;
      end
    end
    last_hs = hs;
    if (hs) begin
      pend         = 1'b1;
      pend_addr    = exp_fetch;
      pend_live    = !rd;
      pend_dly     = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(max_dly));
      last_hs_addr = exp_fetch;
    end
    if (rd) exp_fetch = {tgt[31:2], 2'b00};
    else if (hs) exp_fetch = exp_fetch + 32'd4;
  endtask

  task automatic do_reset(input bit stray);
    rst = 1'b1;
    f.imem_rvalid = stray;
    f.imem_rdata  = 32'hDEAD_BEEF;
    f.imem_gnt    = 1'b0;
    f.redirect    = 1'b0;
    f.redirect_target = '0;
    f.if_ready    = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_imem_req", 32'(f.imem_req), 32'd0);
    cmp("rst_if_valid", 32'(f.if_valid), 32'd0);
    rst = 1'b0;
    q.delete();
    popped.delete();
    exp_fetch = RST_PC;
    pend = 1'b0; pend_live = 1'b0; pend_dly = 0;
    streak = 0; tick_no = 0; first_valid = 0;
    force_rdr = 1'b0; last_hs = 1'b0;
  endtask

  initial begin : wrap_side
    logic [31:0] a;
    bit pv;
    pv = 1'b0; a = '0;
    f2.imem_gnt = 1'b1; f2.imem_rvalid = 1'b0; f2.imem_rdata = '0;
    f2.if_ready = 1'b1; f2.redirect = 1'b0; f2.redirect_target = '0;
    forever begin
      @(negedge clk);
      if (f2.if_valid && n2 < 2) begin
        cap_pc[n2] = f2.if_pc; cap_p4[n2] = f2.if_pc_plus4; cap_in[n2] = f2.if_instr;
        n2++;
      end
      f2.imem_rvalid = pv && !rst;
      f2.imem_rdata  = memfn(a);
      pv = f2.imem_req && !rst;
      a  = f2.imem_addr;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit found;
    int mark;
    // streaming at full rate: pcs 0,4,8 with their data, first valid 3 cycles after release
    do_reset(1'b0);
    gnt_pct = 100; rdy_pct = 100; fixed_dly = 0; stray_pct = 0; redir_pct = 0;
    repeat (10) tick();
    cmp("first_valid_latency", 32'(first_valid), 32'd3);
    cmp("stream_pc0", pop_at(0), 32'h0);
    cmp("stream_pc1", pop_at(1), 32'h4);
    cmp("stream_pc2", pop_at(2), 32'h8);
    cmp("model_memfn_4", memfn(32'h4), 32'h0004_FFFB);

    // decode stalled: buffer fills to DEPTH, requests stop, then drains in order
    do_reset(1'b0);
    rdy_pct = 0;
    repeat (12) tick();
    cmp("stall_no_req", 32'(f.imem_req), 32'd0);
    cmp("stall_head_pc", f.if_pc, 32'h0);
    rdy_pct = 100;
    repeat (3) tick();
    cmp("drain_pc0", pop_at(0), 32'h0);
    cmp("drain_pc1", pop_at(1), 32'h4);
    cmp("drain_only_depth", 32'(f.if_valid), 32'd0);

    // redirect to 0x100 while waiting on 0x8
    do_reset(1'b0);
    fixed_dly = 1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (last_hs && last_hs_addr == 32'h8) begin found = 1'b1; break; end
    end
    cmp("reach_wait_8", 32'(found), 32'd1);
    force_rdr = 1'b1; force_tgt = 32'h100;
    tick();
    mark = popped.size();
    tick();
    cmp("flush_after_redirect", 32'(f.if_valid), 32'd0);
    for (int i = 0; i < 20 && popped.size() == mark; i++) tick();
    cmp("after_redirect_pc", pop_at(mark), 32'h100);
    found = 1'b0;
    foreach (popped[i]) if (popped[i] == 32'h8) found = 1'b1;
    cmp("dropped_pc8", 32'(found), 32'd0);

    // unaligned redirect target is word-aligned
    force_rdr = 1'b1; force_tgt = 32'h203;
    tick();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (f.imem_req) begin found = 1'b1; break; end
    end
    cmp("align_req_seen", 32'(found), 32'd1);
    cmp("align_addr", f.imem_addr, 32'h200);

    // reset while a response is outstanding; the late response must be ignored
    do_reset(1'b0);
    fixed_dly = 3;
    for (int i = 0; i < 10 && !last_hs; i++) tick();
    tick();
    do_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (f.imem_req) begin found = 1'b1; break; end
    end
    cmp("post_rst_req_seen", 32'(found), 32'd1);
    cmp("post_rst_addr", f.imem_addr, 32'h0);
    cmp("post_rst_no_valid", 32'(f.if_valid), 32'd0);

    // randomized traffic against the model
    for (int s = 0; s < 4; s++) begin
      do_reset(s[0]);
      gnt_pct   = int'($urandom_range(100, 30));
      rdy_pct   = int'($urandom_range(100, 20));
      max_dly   = int'($urandom_range(3, 0));
      fixed_dly = -1;
      stray_pct = 10;
      redir_pct = 4;
      repeat (700) tick();
    end

    // wrap-around reset pc instance
    cmp("wrap_captures", 32'(n2), 32'd2);
    cmp("wrap_pc0", cap_pc[0], 32'hFFFF_FFFC);
    cmp("wrap_pc0_plus4", cap_p4[0], 32'h0);
    cmp("wrap_instr0", cap_in[0], 32'hFFFC_0003);
    cmp("wrap_pc1", cap_pc[1], 32'h0);
    cmp("wrap_instr1", cap_in[1], 32'h0000_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 redirect  input  1  branch/jump taken; replace fetch stream.
REQ-006 redirect_target  input  32  new fetch address, valid with redirect.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  word-aligned request address.
REQ-009 imem_gnt  input  1  request accepted this cycle.
REQ-010 imem_rvalid  input  1  read data valid.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 if_valid  output  1  instruction available to decode.
REQ-013 if_ready  input  1  decode accepts; pop when if_valid & if_ready.
REQ-014 if_instr  output  32  head instruction.
REQ-015 if_pc  output  32  address of head instruction.
REQ-016 if_pc_plus4  output  32  if_pc + 4, modulo 2^32.

Function
REQ-017 fetch_pc register resets to RESET_PC and increments by 4 (modulo 2^32) on each handshake (imem_req & imem_gnt).
REQ-018 FSM states IDLE, REQ, WAIT; reset state IDLE; at most one memory request outstanding.
REQ-019 IDLE -> REQ when count + outstanding < DEPTH; otherwise stay.
REQ-020 REQ: imem_req=1, imem_addr=fetch_pc; on imem_gnt -> WAIT; imem_addr stable until grant except on redirect.
REQ-021 WAIT: on imem_rvalid push {fetch address, imem_rdata} into buffer; then -> REQ if space remains after push, else IDLE.
REQ-022 imem_rvalid outside WAIT is ignored.
REQ-023 if_valid = buffer non-empty; if_instr/if_pc/if_pc_plus4 show head entry, combinationally from buffer.
REQ-024 Push and pop in the same cycle leave count unchanged; push into a full buffer never occurs by construction.
REQ-025 Minimum latency: redirect at cycle N, grant at N+1, rvalid at N+2 gives if_valid at N+3.
REQ-026 Redirect: buffer emptied next cycle, fetch_pc <= {redirect_target[31:2],2'b00}; redirect overrides a simultaneous pop or push.
REQ-027 Redirect in REQ without gnt: stay REQ, new address presented next cycle.
REQ-028 Redirect in REQ with gnt, or in WAIT before rvalid: set discard flag; the in-flight response is dropped, then -> REQ at new address.
REQ-029 Redirect coincident with rvalid in WAIT: response dropped, -> REQ.
REQ-030 Redirect in IDLE: -> REQ at new address next cycle.

Reset
REQ-031 On rst: state IDLE, fetch_pc=RESET_PC, buffer empty, discard flag 0, imem_req=0, if_valid=0.
REQ-032 Reset mid-transaction abandons any outstanding request; a later stray rvalid is ignored per REQ-022.

Structure
REQ-033 Shared package riscv_pkg holds XLEN=32, the fetch FSM state enum, and the PC increment constant 4.
REQ-034 Buffer is one sub-module, fetch_fifo (DEPTH entries of 64 bits, push/pop/flush, count output).

Verification
REQ-035 Reset release, memory grants every cycle, rvalid one cycle after grant, if_ready=1 -> if_pc sequence 0x0,0x4,0x8 with matching if_instr; at most one outstanding request.
REQ-036 if_ready=0 for 10 cycles -> exactly DEPTH=2 instructions buffered, imem_req=0 thereafter; if_ready=1 -> pops in order 0x0,0x4.
REQ-037 Redirect to 0x100 while in WAIT for 0x8 -> 0x8 data dropped, next if_pc=0x100, buffer empty the cycle after redirect.
REQ-038 redirect_target=0x203 -> imem_addr=0x200.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first if_pc=0xFFFFFFFC with if_pc_plus4=0x0, second if_pc=0x0.
REQ-040 rst asserted while in WAIT, rvalid arrives next cycle -> if_valid stays 0; first fetch after release is RESET_PC.
